// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone arbiters.
package wb_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    TOERR = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational two-way round-robin picker: one-hot grant, favouring the
// requester that did not win last time.
module wb_rr_pick
  import wb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // pick winner from request vector and last owner
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == M0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin ownership per
// cycle and a watchdog that terminates unanswered transfers with err.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT      = 255,
  parameter int DEFAULT_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_data_wr,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_data_rd,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_data_wr,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_data_rd,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_data_wr,
  input  logic              s_ack,
  input  logic              s_err,
  input  logic [DATA_W-1:0] s_data_rd,
  output logic [1:0]        o_grant,
  output logic              o_timeout
);

  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_FIRE = WDOG_W'(TIMEOUT - 1);
  localparam logic LAST_RST = (DEFAULT_PRIO == 0) ? M1 : M0;

  arb_state_e        state_r, state_s;
  logic [1:0]        grant_r, grant_s, pick_s;
  logic              last_r, last_s;
  logic [WDOG_W-1:0] wdog_r, wdog_s;
  logic              timeout_r, timeout_s;

  logic              g_cyc_s, g_stb_s, g_we_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic [SEL_W-1:0]  g_sel_s;
  logic [DATA_W-1:0] g_data_s;

  wb_rr_pick u_pick (
    .req   ({m1_cyc, m0_cyc}),
    .last  (last_r),
    .grant (pick_s)
  );

  assign g_cyc_s  = grant_r[1] ? m1_cyc     : m0_cyc;
  assign g_stb_s  = grant_r[1] ? m1_stb     : m0_stb;
  assign g_we_s   = grant_r[1] ? m1_we      : m0_we;
  assign g_addr_s = grant_r[1] ? m1_addr    : m0_addr;
  assign g_sel_s  = grant_r[1] ? m1_sel     : m0_sel;
  assign g_data_s = grant_r[1] ? m1_data_wr : m0_data_wr;

  assign o_grant   = grant_r;
  assign o_timeout = timeout_r;

  // next-state, grant, round-robin history and watchdog
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    last_s    = last_r;
    wdog_s    = wdog_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        wdog_s = '0;
        if (pick_s != 2'b00) begin
          grant_s = pick_s;
          last_s  = pick_s[1];
          state_s = OWN;
        end else begin
          grant_s = 2'b00;
        end
      end
      OWN: begin
        if (!g_cyc_s) begin
          state_s = IDLE;
          grant_s = 2'b00;
          wdog_s  = '0;
        end else if (s_ack || s_err) begin
          // a response on the firing cycle beats the watchdog
          wdog_s = '0;
        end else if (g_stb_s) begin
          if (wdog_r >= WDOG_FIRE) begin
            state_s   = TOERR;
            timeout_s = 1'b1;
            wdog_s    = WDOG_MAX;
          end else begin
            wdog_s = wdog_r + WDOG_W'(1);
          end
        end else begin
          wdog_s = wdog_r;
        end
      end
      TOERR: begin
        state_s = IDLE;
        grant_s = 2'b00;
      end
      default: begin
        state_s = IDLE;
        grant_s = 2'b00;
        wdog_s  = '0;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      grant_r   <= 2'b00;
      last_r    <= LAST_RST;
      wdog_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      last_r    <= last_s;
      wdog_r    <= wdog_s;
      timeout_r <= timeout_s;
    end
  end

  // bus routing between the owning master and the slave
  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_sel      = '0;
    s_data_wr  = '0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_data_rd = '0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_data_rd = '0;
    case (state_r)
      OWN: begin
        s_cyc     = g_cyc_s;
        s_stb     = g_stb_s;
        s_we      = g_we_s;
        s_addr    = g_addr_s;
        s_sel     = g_sel_s;
        s_data_wr = g_data_s;
        if (grant_r[1]) begin
          m1_ack     = s_ack;
          m1_err     = s_err;
          m1_data_rd = s_data_rd;
        end else begin
          m0_ack     = s_ack;
          m0_err     = s_err;
          m0_data_rd = s_data_rd;
        end
      end
      TOERR: begin
        if (grant_r[1]) begin
          m1_err = 1'b1;
        end else begin
          m0_err = 1'b1;
        end
      end
      default: begin
        s_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: behavioural slave with programmable
// latency, per-scenario tasks, and queue-based expected grants/read data.
module tb_wb_arbiter2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_data_wr = '0;
  logic [3:0]  m0_sel = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_data_rd;
  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_data_wr = '0;
  logic [3:0]  m1_sel = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_data_rd;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_addr, s_data_wr;
  logic [3:0]  s_sel;
  logic        sack = 1'b0;
  logic        serr = 1'b0;
  logic [31:0] srd = '0;
  logic [1:0]  o_grant;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [1:0]  gnt_q[$];

  wb_arbiter2 #(.TIMEOUT(8), .DEFAULT_PRIO(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_sel(m0_sel), .m0_data_wr(m0_data_wr), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_data_rd(m0_data_rd),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_sel(m1_sel), .m1_data_wr(m1_data_wr), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_data_rd(m1_data_rd),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel),
    .s_data_wr(s_data_wr), .s_ack(sack), .s_err(serr), .s_data_rd(srd),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // slave model: accepts a request, answers after lat extra cycles, never resets
  logic [31:0] mem [0:255];
  logic        pend = 1'b0, l_we = 1'b0, mute = 1'b0;
  logic [31:0] l_addr = '0, l_data = '0;
  int          cnt = 0, lat = 0;
  always @(posedge i_clk) begin
    sack <= 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        pend <= 1'b0;
        sack <= 1'b1;
        if (l_we) mem[l_addr[9:2]] <= l_data;
        else srd <= mem[l_addr[9:2]];
      end else begin
        cnt <= cnt - 1;
      end
    end else if (!sack && s_cyc && s_stb && !mute) begin
      if (lat == 0) begin
        sack <= 1'b1;
        if (s_we) mem[s_addr[9:2]] <= s_data_wr;
        else srd <= mem[s_addr[9:2]];
      end else begin
        pend   <= 1'b1;
        cnt    <= lat - 1;
        l_we   <= s_we;
        l_addr <= s_addr;
        l_data <= s_data_wr;
      end
    end
  end

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_sel = 4'hF; m0_data_wr = wd;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_sel = 4'hF; m1_data_wr = wd;
    end
  endtask

  // one single-beat transfer; ok=0 if no response arrives within the budget
  task automatic xfer(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic ack, output logic err, output logic ok);
    @(negedge i_clk);
    drive(m, 1'b1, 1'b1, we, addr, wd);
    rd = '0; ack = 1'b0; err = 1'b0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (m == 0 ? (m0_ack || m0_err) : (m1_ack || m1_err)) begin
        ack = (m == 0) ? m0_ack : m1_ack;
        err = (m == 0) ? m0_err : m1_err;
        rd  = (m == 0) ? m0_data_rd : m1_data_rd;
        ok  = 1'b1;
        break;
      end
    end
    drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic apply_reset;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", o_grant); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", o_timeout); end
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin errors++; $display("FAIL rst_slave got cyc=%b stb=%b want 0/0", s_cyc, s_stb); end
    checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin errors++; $display("FAIL rst_acks got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL rst_hold_grant got %b want 00", o_grant); end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    i_rst = 1'b0;
  endtask

  task automatic test_single;
    logic [31:0] rd, e;
    logic ak, er, ok;
    int stray = 0;
    lat = 0;
    @(negedge i_clk);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    checks++; if (o_grant !== 2'b00 || s_stb !== 1'b0) begin errors++; $display("FAIL single_pre got grant=%b stb=%b want 00/0", o_grant, s_stb); end
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_grant got %b want 01", o_grant); end
    checks++; if (s_stb !== 1'b1 || s_we !== 1'b1 || s_addr !== 32'h10 || s_sel !== 4'hF || s_data_wr !== 32'hDEADBEEF)
      begin errors++; $display("FAIL single_route got stb=%b we=%b addr=%h sel=%h data=%h want 1/1/10/f/deadbeef", s_stb, s_we, s_addr, s_sel, s_data_wr); end
    ak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m1_ack || m1_err) stray++;
      if (m0_ack) begin ak = 1'b1; break; end
      @(negedge i_clk);
    end
    checks++; if (ak !== 1'b1) begin errors++; $display("FAIL single_wr_ack got %b want 1", ak); end
    checks++; if (stray != 0) begin errors++; $display("FAIL single_m1_stray got %0d want 0", stray); end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, ak, er, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || ak !== 1'b1 || rd !== e) begin errors++; $display("FAIL single_rd got ok=%b ack=%b data=%h want 1/1/%h", ok, ak, rd, e); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd0, rd1;
    logic ak0, er0, ok0, ak1, er1, ok1;
    logic [1:0] prev, e;
    int a0 = 0, a1 = 0, stray = 0, bad = 0;
    bit d0 = 0, d1 = 0;
    apply_reset();
    lat = 0;
    for (int k = 0; k < 3; k++) begin gnt_q.push_back(2'b01); gnt_q.push_back(2'b10); end
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          xfer(0, 1'b1, 32'h100 + 32'(k * 4), 32'hA000 + 32'(k), rd0, ak0, er0, ok0);
          if (!ok0 || !ak0) bad++;
        end
        d0 = 1;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          xfer(1, 1'b1, 32'h200 + 32'(k * 4), 32'hB000 + 32'(k), rd1, ak1, er1, ok1);
          if (!ok1 || !ak1) bad++;
        end
        d1 = 1;
      end
      begin
        prev = 2'b00;
        for (int i = 0; i < 400 && !(d0 && d1); i++) begin
          @(negedge i_clk);
          if (o_grant != prev && o_grant != 2'b00) begin
            if (gnt_q.size() == 0) begin
              checks++; errors++; $display("FAIL b2b_extra_grant got %b want none", o_grant);
            end else begin
              e = gnt_q.pop_front();
              checks++; if (o_grant !== e) begin errors++; $display("FAIL b2b_order got %b want %b", o_grant, e); end
            end
          end
          prev = o_grant;
          if (m0_ack) a0++;
          if (m1_ack) a1++;
          if ((m0_ack && o_grant !== 2'b01) || (m1_ack && o_grant !== 2'b10)) stray++;
        end
      end
    join
    checks++; if (gnt_q.size() != 0) begin errors++; $display("FAIL b2b_missing_grants got %0d left want 0", gnt_q.size()); end
    checks++; if (a0 != 3 || a1 != 3) begin errors++; $display("FAIL b2b_ack_count got %0d/%0d want 3/3", a0, a1); end
    checks++; if (stray != 0 || bad != 0) begin errors++; $display("FAIL b2b_stray got stray=%0d bad=%0d want 0/0", stray, bad); end
    gnt_q.delete();
  endtask

  task automatic test_locked;
    int beats = 0, stray = 0;
    logic got;
    logic [31:0] e;
    lat = 0;
    @(negedge i_clk);
    drive(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
    @(negedge i_clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < 60 && beats < 4; i++) begin
      @(negedge i_clk);
      if (m0_ack || m0_err) stray++;
      if (m1_ack) begin
        beats++;
        checks++; if (o_grant !== 2'b10) begin errors++; $display("FAIL locked_grant beat %0d got %b want 10", beats, o_grant); end
        if (beats < 4) drive(1, 1'b1, 1'b1, 1'b1, 32'h40 + 32'(beats * 4), 32'(beats));
        else drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checks++; if (beats != 4 || stray != 0) begin errors++; $display("FAIL locked_beats got %0d stray %0d want 4/0", beats, stray); end
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL locked_idle got %b want 00", o_grant); end
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL locked_handoff got %b want 01", o_grant); end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m0_ack) begin got = 1'b1; break; end
      @(negedge i_clk);
    end
    e = exp_q.pop_front();
    checks++; if (!got || m0_data_rd !== e) begin errors++; $display("FAIL locked_m0_rd got ack=%b data=%h want 1/%h", got, m0_data_rd, e); end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_timeout;
    int n = 0;
    logic got = 1'b0;
    logic [31:0] rd, e;
    logic ak, er, ok;
    mute = 1'b1;
    @(negedge i_clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (m0_err) begin got = 1'b1; break; end
      if (s_stb) n++;
    end
    checks++; if (!got) begin errors++; $display("FAIL tmo_err got 0 want 1"); end
    checks++; if (n != 8) begin errors++; $display("FAIL tmo_stb_cycles got %0d want 8", n); end
    checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %b want 1", o_timeout); end
    checks++; if (m0_ack !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("FAIL tmo_ack got m0_ack=%b m1_err=%b want 0/0", m0_ack, m1_err); end
    checks++; if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin errors++; $display("FAIL tmo_bus got cyc=%b stb=%b want 0/0", s_cyc, s_stb); end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    checks++; if (o_timeout !== 1'b0 || m0_err !== 1'b0 || o_grant !== 2'b00) begin errors++; $display("FAIL tmo_after got tmo=%b err=%b grant=%b want 0/0/00", o_timeout, m0_err, o_grant); end
    mute = 1'b0;
    xfer(0, 1'b1, 32'h20, 32'h12345678, rd, ak, er, ok);
    checks++; if (!ok || ak !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL tmo_recover_wr got ok=%b ack=%b err=%b want 1/1/0", ok, ak, er); end
    exp_q.push_back(32'h12345678);
    xfer(0, 1'b0, 32'h20, 32'h0, rd, ak, er, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || rd !== e) begin errors++; $display("FAIL tmo_recover_rd got %h want %h", rd, e); end
  endtask

  task automatic test_late_ack;
    int n = 0;
    logic tseen = 1'b0, ak = 1'b0, er = 1'b0;
    logic [31:0] rd = '0, e;
    lat = 6;
    exp_q.push_back(32'h12345678);
    @(negedge i_clk);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_timeout) tseen = 1'b1;
      if (s_stb) n++;
      if (m0_ack || m0_err) begin ak = m0_ack; er = m0_err; rd = m0_data_rd; break; end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge i_clk);
      if (o_timeout) tseen = 1'b1;
    end
    e = exp_q.pop_front();
    checks++; if (ak !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL late_ack got ack=%b err=%b want 1/0", ak, er); end
    checks++; if (n != 8) begin errors++; $display("FAIL late_cycle got %0d want 8", n); end
    checks++; if (tseen !== 1'b0) begin errors++; $display("FAIL late_no_timeout got %b want 0", tseen); end
    checks++; if (rd !== e) begin errors++; $display("FAIL late_data got %h want %h", rd, e); end
    lat = 0;
  endtask

  task automatic test_reset_mid;
    int leak = 0, seen = 0;
    lat = 3;
    @(negedge i_clk);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge i_clk);
    checks++; if (o_grant !== 2'b00 || s_cyc !== 1'b0) begin errors++; $display("FAIL rstmid_bus got grant=%b cyc=%b want 00/0", o_grant, s_cyc); end
    i_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (m0_ack || m1_ack || m0_err || m1_err) leak++;
      if (sack) seen++;
    end
    checks++; if (leak != 0) begin errors++; $display("FAIL rstmid_leak got %0d want 0", leak); end
    checks++; if (seen != 1) begin errors++; $display("FAIL rstmid_slave_ack got %0d want 1", seen); end
    lat = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_locked();
    test_timeout();
    test_late_ack();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
